// File: rtl/noc_params.sv
// Shared router parameters.
//   PORT_NUM / VC_NUM / BUFFER_SIZE : default router geometry
//   PORT_SIZE / VC_SIZE             : index widths for ports and virtual channels
//   port_t                          : symbolic names of the five mesh ports
package noc_params;

  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int BUFFER_SIZE = 8;

  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VC_SIZE   = $clog2(VC_NUM);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

endpackage

// File: rtl/separable_input_first_allocator.sv
// Separable input-first allocator.
// Stage 1 lets every agent pick one of its requested resources round-robin;
// stage 2 lets every resource pick one of the agents that picked it, round-robin.
// Both priority pointers advance only on a final grant, to the slot after the winner.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointers back to 0)
//   requests_i  : [agent][resource] request matrix
//   grants_o    : [agent][resource] grant matrix, at most one bit per row and column
module separable_input_first_allocator #(
  parameter int AGENTS_NUM    = 5,
  parameter int RESOURCES_NUM = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]    requests_i,
  output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]    grants_o
);

  localparam int AG_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;
  localparam int RS_W = (RESOURCES_NUM > 1) ? $clog2(RESOURCES_NUM) : 1;

  logic [AGENTS_NUM-1:0][RS_W-1:0]               r_in_ptr;
  logic [AGENTS_NUM-1:0][RS_W-1:0]               w_in_ptr_nxt;
  logic [RESOURCES_NUM-1:0][AG_W-1:0]            r_out_ptr;
  logic [RESOURCES_NUM-1:0][AG_W-1:0]            w_out_ptr_nxt;
  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]      w_in_sel;
  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]      w_grant;
  logic [AGENTS_NUM-1:0]                         w_in_won;
  logic [RESOURCES_NUM-1:0]                      w_out_won;

  // Stage 1: per-agent round-robin over its own requests.
  always_comb begin
    logic            found;
    logic [RS_W:0]   sum;
    w_in_sel = '0;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      found = 1'b0;
      for (int k = 0; k < RESOURCES_NUM; k++) begin
        sum = {1'b0, r_in_ptr[a]} + (RS_W+1)'(k);
        if (sum >= (RS_W+1)'(RESOURCES_NUM)) sum = sum - (RS_W+1)'(RESOURCES_NUM);
        if (!found && requests_i[a][sum[RS_W-1:0]]) begin
          w_in_sel[a][sum[RS_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // Stage 2: per-resource round-robin over the agents that selected it.
  always_comb begin
    logic            found;
    logic [AG_W:0]   sum;
    w_grant       = '0;
    w_out_won     = '0;
    w_out_ptr_nxt = r_out_ptr;
    for (int r = 0; r < RESOURCES_NUM; r++) begin
      found = 1'b0;
      for (int k = 0; k < AGENTS_NUM; k++) begin
        sum = {1'b0, r_out_ptr[r]} + (AG_W+1)'(k);
        if (sum >= (AG_W+1)'(AGENTS_NUM)) sum = sum - (AG_W+1)'(AGENTS_NUM);
        if (!found && w_in_sel[sum[AG_W-1:0]][r]) begin
          w_grant[sum[AG_W-1:0]][r] = 1'b1;
          found = 1'b1;
          w_out_won[r] = 1'b1;
          // Winner drops to lowest priority for the next round.
          if (sum + (AG_W+1)'(1) >= (AG_W+1)'(AGENTS_NUM)) w_out_ptr_nxt[r] = '0;
          else                                             w_out_ptr_nxt[r] = sum[AG_W-1:0] + AG_W'(1);
        end
      end
    end
  end

  // Input pointers move only when the stage-1 choice actually won.
  always_comb begin
    w_in_won     = '0;
    w_in_ptr_nxt = r_in_ptr;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      for (int r = 0; r < RESOURCES_NUM; r++) begin
        if (w_grant[a][r]) begin
          w_in_won[a] = 1'b1;
          if (r + 1 >= RESOURCES_NUM) w_in_ptr_nxt[a] = '0;
          else                        w_in_ptr_nxt[a] = RS_W'(r + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ptr  <= '0;
      r_out_ptr <= '0;
    end else begin
      for (int a = 0; a < AGENTS_NUM; a++) begin
        if (w_in_won[a]) r_in_ptr[a] <= w_in_ptr_nxt[a];
      end
      for (int r = 0; r < RESOURCES_NUM; r++) begin
        if (w_out_won[r]) r_out_ptr[r] <= w_out_ptr_nxt[r];
      end
    end
  end

  assign grants_o = w_grant;

endmodule

// File: rtl/credit_switch_scheduler.sv
// Switch-allocation stage of the router.
// Picks one eligible VC per input (round-robin, needs a flit and a downstream credit),
// sends one output request per input into the separable allocator, registers the
// resulting switch/crossbar configuration and tracks downstream credits per output VC.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   vc_valid_i        : [port][vc] VC holds a flit ready to traverse the switch
//   out_port_i        : [port][vc] routed output port of the head flit
//   downstream_vc_i   : [port][vc] downstream VC assigned by VC allocation
//   credit_valid_i    : [out] one credit returned on that output
//   credit_vc_i       : [out] downstream VC the returned credit belongs to
//   sa_valid_o/sa_vc_o: registered per-input grant and winning VC
//   xbar_valid_o/xbar_sel_o : registered per-output enable and selected input
//   credit_err_o      : sticky credit overflow flag
module credit_switch_scheduler #(
  parameter  int PORT_NUM    = noc_params::PORT_NUM,
  parameter  int VC_NUM      = noc_params::VC_NUM,
  parameter  int BUFFER_SIZE = noc_params::BUFFER_SIZE,
  localparam int PORT_SIZE   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                 vc_valid_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]  out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_i,
  input  logic [PORT_NUM-1:0]                             credit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]                credit_vc_i,
  output logic [PORT_NUM-1:0]                             sa_valid_o,
  output logic [PORT_NUM-1:0][VC_SIZE-1:0]                sa_vc_o,
  output logic [PORT_NUM-1:0]                             xbar_valid_o,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]              xbar_sel_o,
  output logic                                            credit_err_o
);

  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_W-1:0]  r_credit_cnt;
  logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_W-1:0]  w_credit_nxt;
  logic                                        w_err_set;
  logic                                        r_credit_err;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]            r_vc_ptr;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]            w_vc_ptr_nxt;

  logic [PORT_NUM-1:0][VC_NUM-1:0]             w_elig;
  logic [PORT_NUM-1:0]                         w_has_cand;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]            w_cand;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]            w_cand_dvc;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]           w_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]           w_gnt;
  logic [PORT_NUM-1:0]                         w_in_gnt;
  logic [PORT_NUM-1:0]                         w_xbar_valid;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]          w_xbar_sel;

  logic [PORT_NUM-1:0]                         r_sa_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]            r_sa_vc;
  logic [PORT_NUM-1:0]                         r_xbar_valid;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]          r_xbar_sel;

  // Eligibility uses the registered count only, so a credit returned this cycle
  // is not usable until the next one. Out-of-range port/VC codes are never eligible.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (vc_valid_i[i][v] &&
            ({1'b0, out_port_i[i][v]} < (PORT_SIZE+1)'(PORT_NUM)) &&
            ({1'b0, downstream_vc_i[i][v]} < (VC_SIZE+1)'(VC_NUM))) begin
          w_elig[i][v] = (r_credit_cnt[out_port_i[i][v]][downstream_vc_i[i][v]] != '0);
        end
      end
    end
  end

  // Candidate: first eligible VC starting at vc_ptr, wrapping.
  always_comb begin
    logic [VC_SIZE:0] sum;
    w_has_cand   = '0;
    w_cand       = '0;
    w_vc_ptr_nxt = r_vc_ptr;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        sum = {1'b0, r_vc_ptr[i]} + (VC_SIZE+1)'(k);
        if (sum >= (VC_SIZE+1)'(VC_NUM)) sum = sum - (VC_SIZE+1)'(VC_NUM);
        if (!w_has_cand[i] && w_elig[i][sum[VC_SIZE-1:0]]) begin
          w_has_cand[i] = 1'b1;
          w_cand[i]     = sum[VC_SIZE-1:0];
          if (sum + (VC_SIZE+1)'(1) >= (VC_SIZE+1)'(VC_NUM)) w_vc_ptr_nxt[i] = '0;
          else                                               w_vc_ptr_nxt[i] = sum[VC_SIZE-1:0] + VC_SIZE'(1);
        end
      end
    end
  end

  always_comb begin
    w_req      = '0;
    w_cand_dvc = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      w_cand_dvc[i] = downstream_vc_i[i][w_cand[i]];
      if (w_has_cand[i]) w_req[i][out_port_i[i][w_cand[i]]] = 1'b1;
    end
  end

  separable_input_first_allocator #(
    .AGENTS_NUM    (PORT_NUM),
    .RESOURCES_NUM (PORT_NUM)
  ) u_alloc (
    .clk        (clk),
    .rst        (rst),
    .requests_i (w_req),
    .grants_o   (w_gnt)
  );

  // Grant matrix -> per-input and per-output views.
  always_comb begin
    w_in_gnt     = '0;
    w_xbar_valid = '0;
    w_xbar_sel   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (w_gnt[i][o]) begin
          w_in_gnt[i]     = 1'b1;
          w_xbar_valid[o] = 1'b1;
          w_xbar_sel[o]   = PORT_SIZE'(i);
        end
      end
    end
  end

  // Credit update: a grant and a return on the same counter cancel out;
  // a lone return on a full counter is dropped and flagged.
  always_comb begin
    logic dec;
    logic inc;
    w_credit_nxt = r_credit_cnt;
    w_err_set    = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int d = 0; d < VC_NUM; d++) begin
        dec = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
          if (w_gnt[i][o] && (w_cand_dvc[i] == VC_SIZE'(d))) dec = 1'b1;
        end
        inc = credit_valid_i[o] && (credit_vc_i[o] == VC_SIZE'(d));
        if (dec && !inc) begin
          w_credit_nxt[o][d] = r_credit_cnt[o][d] - CNT_W'(1);
        end else if (inc && !dec) begin
          if (r_credit_cnt[o][d] == CNT_W'(BUFFER_SIZE)) w_err_set = 1'b1;
          else w_credit_nxt[o][d] = r_credit_cnt[o][d] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int d = 0; d < VC_NUM; d++) begin
          r_credit_cnt[o][d] <= CNT_W'(BUFFER_SIZE);
        end
      end
      r_credit_err <= 1'b0;
      r_vc_ptr     <= '0;
      r_sa_valid   <= '0;
      r_sa_vc      <= '0;
      r_xbar_valid <= '0;
      r_xbar_sel   <= '0;
    end else begin
      r_credit_cnt <= w_credit_nxt;
      r_credit_err <= r_credit_err | w_err_set;
      r_sa_valid   <= w_in_gnt;
      r_xbar_valid <= w_xbar_valid;
      r_xbar_sel   <= w_xbar_sel;
      for (int i = 0; i < PORT_NUM; i++) begin
        r_sa_vc[i] <= w_in_gnt[i] ? w_cand[i] : '0;
        if (w_in_gnt[i]) r_vc_ptr[i] <= w_vc_ptr_nxt[i];
      end
    end
  end

  assign sa_valid_o   = r_sa_valid;
  assign sa_vc_o      = r_sa_vc;
  assign xbar_valid_o = r_xbar_valid;
  assign xbar_sel_o   = r_xbar_sel;
  assign credit_err_o = r_credit_err;

endmodule
